// File: rtl/escalonador_datapath.sv
// -----------------------------------------------------------------------------
// escalonador_datapath
// Round-robin scheduler that lets two requesters share one multi-cycle
// datapath controller, one operation at a time, with a watchdog on the wait.
//
// Ports
//   clock       : sole clock, rising edge
//   reset       : synchronous active-low reset
//   req0/req1   : requester wants one operation
//   x0/x1       : requester operand, valid while its req is high
//   gnt0/gnt1   : one-cycle acknowledge, operand captured into dp_x
//   done0/done1 : one-cycle pulse, result holds the owner's answer
//   result      : last captured datapath result
//   timeout_err : sticky flag, set when a wait is aborted
//   dp_start    : one-cycle start strobe to the datapath controller
//   dp_x        : operand to the datapath, stable from grant to completion
//   dp_ready    : datapath controller idle
//   dp_valid    : datapath result valid (single cycle)
//   dp_result   : datapath result bus
//
// All outputs are registered. Each strobe appears in the cycle after the
// state that produces it, so a grant-to-done span is 3 + (dp_start to
// dp_valid) cycles. timeout_err is set on the transition into ERR.
// -----------------------------------------------------------------------------
module escalonador_datapath #(
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] result,
    output logic         timeout_err,
    output logic         dp_start,
    output logic [W-1:0] dp_x,
    input  logic         dp_ready,
    input  logic         dp_valid,
    input  logic [W-1:0] dp_result
);

    // Counter just wide enough to hold TIMEOUT itself.
    localparam int            CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_owner, w_owner_nxt;
    logic          r_last_owner, w_last_owner_nxt;
    logic [W-1:0]  r_dp_x, w_dp_x_nxt;
    logic [W-1:0]  r_result, w_result_nxt;
    logic          r_gnt0, w_gnt0_nxt;
    logic          r_gnt1, w_gnt1_nxt;
    logic          r_done0, w_done0_nxt;
    logic          r_done1, w_done1_nxt;
    logic          r_dp_start, w_dp_start_nxt;
    logic          r_timeout_err, w_timeout_err_nxt;
    logic          w_winner;

    // Round robin: a lone request wins; on a tie the one that did not go last wins.
    assign w_winner  = (req0 & req1) ? ~r_last_owner : req1;

    // Saturating increment: the counter holds at TIMEOUT rather than wrapping.
    assign w_cnt_inc = (r_cnt == TMO) ? r_cnt : (r_cnt + CW'(1));

    // Next-state and next-output decode; every target defaults to hold/idle.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_owner_nxt       = r_owner;
        w_last_owner_nxt  = r_last_owner;
        w_dp_x_nxt        = r_dp_x;
        w_result_nxt      = r_result;
        w_gnt0_nxt        = 1'b0;
        w_gnt1_nxt        = 1'b0;
        w_done0_nxt       = 1'b0;
        w_done1_nxt       = 1'b0;
        w_dp_start_nxt    = 1'b0;
        w_timeout_err_nxt = r_timeout_err;
        case (r_state)
            S_IDLE: begin
                if ((req0 | req1) && dp_ready) begin
                    w_owner_nxt = w_winner;
                    w_dp_x_nxt  = w_winner ? x1 : x0;
                    w_gnt0_nxt  = ~w_winner;
                    w_gnt1_nxt  = w_winner;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt      = {CW{1'b0}};
                w_dp_start_nxt = 1'b1;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the deadline cycle still wins over the abort.
                if (dp_valid) begin
                    w_result_nxt = dp_result;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == TMO) begin
                        w_timeout_err_nxt = 1'b1;
                        w_state_nxt       = S_ERR;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                w_done0_nxt      = ~r_owner;
                w_done1_nxt      = r_owner;
                w_last_owner_nxt = r_owner;
                w_state_nxt      = S_IDLE;
            end
            S_ERR: begin
                // Aborted owner still counts as served for fairness.
                w_last_owner_nxt = r_owner;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= {CW{1'b0}};
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_dp_x        <= {W{1'b0}};
            r_result      <= {W{1'b0}};
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_dp_start    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_owner       <= w_owner_nxt;
            r_last_owner  <= w_last_owner_nxt;
            r_dp_x        <= w_dp_x_nxt;
            r_result      <= w_result_nxt;
            r_gnt0        <= w_gnt0_nxt;
            r_gnt1        <= w_gnt1_nxt;
            r_done0       <= w_done0_nxt;
            r_done1       <= w_done1_nxt;
            r_dp_start    <= w_dp_start_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign result      = r_result;
    assign timeout_err = r_timeout_err;
    assign dp_start    = r_dp_start;
    assign dp_x        = r_dp_x;

endmodule
